// File: rtl/instr_mem_pkg.sv
// Shared defaults and FSM state type for the instruction memory path
// (burst writer and fetch unit).
package instr_mem_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 1024;
  localparam int MAX_BURST_DEF = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/instr_ram_1w1r.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read.
// A read that collides with a write returns the old word; out-of-range reads return 0.
module instr_ram_1w1r #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr <= ADDR_W'(DEPTH - 1)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/instr_mem_burst_writer.sv
// Accepts bursts of up to MAX_BURST instruction words and writes them one per
// cycle at an advancing cursor into the instruction RAM; exposes fill flags and a read port.
module instr_mem_burst_writer
  import instr_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_BURST*DATA_W-1:0] in_words,
  input  logic [CNT_W-1:0]            in_count,
  input  logic                        clear,
  output logic                        busy,
  output logic [ADDR_W-1:0]           cursor,
  output logic                        full,
  output logic                        overflow,
  output logic                        bad_count,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data
);

  // Handshake: a burst is transferred on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE and outside reset.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  wr_state_e                   state;
  logic [MAX_BURST*DATA_W-1:0] words_q;
  logic [CNT_W-1:0]            count_q;
  logic [CNT_W-1:0]            idx_q;
  logic                        ram_we;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == WRITE);
  assign ram_we   = (state == WRITE) && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      words_q   <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      cursor    <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      bad_count <= 1'b0;
    end else begin
      bad_count <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            words_q <= in_words;
            count_q <= in_count;
            idx_q   <= '0;
            if (in_count > CNT_W'(MAX_BURST)) begin
              bad_count <= 1'b1;
            end else if (in_count != '0) begin
              state <= WRITE;
            end
          end else if (clear) begin
            cursor   <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        WRITE: begin
          // Once the last address is written the cursor parks there and further words drop.
          if (full) begin
            overflow <= 1'b1;
          end else if (cursor == LAST_ADDR) begin
            full <= 1'b1;
          end else begin
            cursor <= cursor + ADDR_W'(1);
          end
          words_q <= words_q >> DATA_W;
          idx_q   <= idx_q + CNT_W'(1);
          if (idx_q == count_q - CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_ram_1w1r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (cursor),
    .wr_data (words_q[DATA_W-1:0]),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
